// File: rtl/sync_fifo_wr_arbiter.sv
// Packet-level round-robin write arbiter in front of a sync_fifo write port.
// Optional idle watchdog on the granted requester: define FIFO_ARB_WDOG_EN.
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEEP    = 1024,
    parameter int START_THRESH = 1000,
    parameter int MAX_PKT_LEN  = 256
`ifdef FIFO_ARB_WDOG_EN
    ,
    parameter int WDOG_CYCLES  = 64
`endif
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_n_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [$clog2(FIFO_DEEP):0]      fifo_num_i,
    output logic                            fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]           fifo_din_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o,
    output logic                            pkt_err_o
);

    localparam int NW = $clog2(FIFO_DEEP) + 1;
    localparam int CW = $clog2(MAX_PKT_LEN) + 1;
    localparam int IW = $clog2(NUM_REQ);

    localparam logic [NW-1:0] DEEP_N   = NW'(FIFO_DEEP);
    localparam logic [NW-1:0] THRESH_N = NW'(START_THRESH);
    localparam logic [CW-1:0] MAX_N    = CW'(MAX_PKT_LEN);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [IW-1:0]        rr_ptr_q;
    logic [CW-1:0]        beat_cnt_q;
    logic                 pkt_err_q;

    logic                 space_ok;
    logic                 start_ok;
    logic                 xfer;
    logic                 g_valid;
    logic                 g_last;
    logic [DATA_WIDTH-1:0] g_data;
    logic                 found_d;
    logic [IW-1:0]        sel_d;
    logic [CW-1:0]        cnt_inc;
    logic                 max_hit;

    assign space_ok = fifo_num_i < DEEP_N;
    assign start_ok = fifo_num_i < THRESH_N;

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_valid = req_valid_i[i];
                g_last  = req_last_i[i];
                g_data  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        int idx;
        idx     = 0;
        found_d = 1'b0;
        sel_d   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found_d && req_valid_i[idx]) begin
                found_d = 1'b1;
                sel_d   = IW'(idx);
            end
        end
    end

    assign req_ready_o  = (rst_n_i && state_q == BUSY && space_ok)
                          ? grant_q : '0;
    assign xfer         = |(req_valid_i & req_ready_o);
    assign fifo_wr_en_o = xfer;
    assign fifo_din_o   = g_data;

    assign cnt_inc = beat_cnt_q + 1'b1;
    assign max_hit = cnt_inc == MAX_N;

    assign grant_o   = grant_q;
    assign busy_o    = state_q == BUSY;
    assign pkt_err_o = pkt_err_q;

`ifdef FIFO_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
    logic [WW-1:0] wdog_q;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            pkt_err_q  <= 1'b0;
`ifdef FIFO_ARB_WDOG_EN
            wdog_q     <= '0;
`endif
        end else begin
            pkt_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d && start_ok) begin
                        state_q    <= BUSY;
                        grant_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_d;
                        rr_ptr_q   <= sel_d;
                        beat_cnt_q <= '0;
`ifdef FIFO_ARB_WDOG_EN
                        wdog_q     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (xfer) begin
                        beat_cnt_q <= cnt_inc;
`ifdef FIFO_ARB_WDOG_EN
                        wdog_q     <= '0;
`endif
                        if (g_last) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end else if (max_hit) begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            pkt_err_q <= 1'b1;
                        end
                    end
`ifdef FIFO_ARB_WDOG_EN
                    // A space stall freezes the idle count rather than aging it.
                    else if (g_valid) begin
                        wdog_q <= '0;
                    end else if (space_ok) begin
                        if (wdog_q == WDOG_LAST) begin
                            state_q   <= IDLE;
                            grant_q   <= '0;
                            pkt_err_q <= 1'b1;
                            wdog_q    <= '0;
                        end else begin
                            wdog_q <= wdog_q + 1'b1;
                        end
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed testbench for sync_fifo_wr_arbiter (MAX_PKT_LEN reduced to 4).
module tb_sync_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  valid = '0;
    logic [31:0] data = '0;
    logic [3:0]  last = '0;
    logic [3:0]  ready;
    logic [10:0] fifo_num = '0;
    logic        wr_en;
    logic [7:0]  din;
    logic [3:0]  grant;
    logic        busy;
    logic        pkt_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_wr_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(8), .FIFO_DEEP(1024),
        .START_THRESH(1000), .MAX_PKT_LEN(4)
    ) dut (
        .sys_clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
        .req_ready_o(ready), .fifo_num_i(fifo_num),
        .fifo_wr_en_o(wr_en), .fifo_din_o(din),
        .grant_o(grant), .busy_o(busy), .pkt_err_o(pkt_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int r, input logic [7:0] v);
        data[r*8 +: 8] = v;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; valid = '0; last = '0; data = '0; fifo_num = '0;
        tick; tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valid = 4'hF; fifo_num = '0; data = 32'hDEADBEEF;
        tick; tick;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: got %b, expected 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b, expected 0", pkt_err); end
        checks++; if (ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b, expected 0000", ready); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b, expected 0", wr_en); end
        checks++; if (din !== 8'h00) begin errors++; $display("FAIL rst_din: got %h, expected 00", din); end
    endtask

    task automatic test_single;
        logic [7:0] exp_d;
        do_reset;
        valid = 4'b0010; set_data(1, 8'hA1); #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_idle_grant: got %b, expected 0000", grant); end
        tick;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL t1_grant: got %b, expected 0010", grant); end
        for (int b = 0; b < 3; b++) begin
            exp_d = 8'hA1 + 8'(b);
            set_data(1, exp_d);
            last = (b == 2) ? 4'b0010 : 4'b0000;
            #1;
            checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL t1_wr_en beat %0d: got %b, expected 1", b, wr_en); end
            checks++; if (din !== exp_d) begin errors++; $display("FAIL t1_din beat %0d: got %h, expected %h", b, din, exp_d); end
            tick;
        end
        valid = '0; last = '0; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL t1_end_grant: got %b, expected 0000", grant); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL t1_end_wr_en: got %b, expected 0", wr_en); end
    endtask

    task automatic test_round_robin;
        int g;
        logic [7:0] exp_d;
        do_reset;
        valid = 4'hF;
        for (int p = 0; p < 5; p++) begin
            g = p % 4;
            for (int i = 0; i < 4; i++) set_data(i, 8'(16 * i));
            last = '0; #1;
            checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rr_gap pkt %0d: got %b, expected 0000", p, grant); end
            tick;
            checks++; if (grant !== 4'(1 << g)) begin errors++; $display("FAIL rr_grant pkt %0d: got %b, expected %b", p, grant, 4'(1 << g)); end
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < 4; i++) set_data(i, 8'(16 * i + b));
                last = (b == 1) ? 4'hF : 4'h0;
                exp_d = 8'(16 * g + b);
                #1;
                checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL rr_wr_en pkt %0d beat %0d: got %b, expected 1", p, b, wr_en); end
                checks++; if (din !== exp_d) begin errors++; $display("FAIL rr_din pkt %0d beat %0d: got %h, expected %h", p, b, din, exp_d); end
                checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL rr_err pkt %0d: got %b, expected 0", p, pkt_err); end
                tick;
            end
        end
        valid = '0; last = '0;
    endtask

    task automatic test_space_stall;
        do_reset;
        valid = 4'b0001; set_data(0, 8'hB0); #1;
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL st_grant: got %b, expected 0001", grant); end
        checks++; if (wr_en !== 1'b1 || din !== 8'hB0) begin errors++; $display("FAIL st_b0: got wr_en=%b din=%h, expected 1/b0", wr_en, din); end
        tick;
        set_data(0, 8'hB1); fifo_num = 11'd1024;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (ready !== 4'b0000 || wr_en !== 1'b0) begin errors++; $display("FAIL st_stall cyc %0d: got ready=%b wr_en=%b, expected 0000/0", c, ready, wr_en); end
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL st_hold cyc %0d: got %b, expected 0001", c, grant); end
            tick;
        end
        fifo_num = 11'd1023; #1;
        checks++; if (wr_en !== 1'b1 || din !== 8'hB1) begin errors++; $display("FAIL st_b1: got wr_en=%b din=%h, expected 1/b1", wr_en, din); end
        tick;
        set_data(0, 8'hB2); last = 4'b0001; #1;
        checks++; if (wr_en !== 1'b1 || din !== 8'hB2) begin errors++; $display("FAIL st_b2: got wr_en=%b din=%h, expected 1/b2", wr_en, din); end
        tick;
        valid = '0; last = '0; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL st_end: got %b, expected 0000", grant); end
    endtask

    task automatic test_start_thresh;
        do_reset;
        fifo_num = 11'd1000; valid = 4'b0001; set_data(0, 8'h55); last = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL th_hold cyc %0d: got grant=%b busy=%b, expected 0000/0", c, grant, busy); end
        end
        fifo_num = 11'd999;
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL th_grant: got %b, expected 0001", grant); end
        #1;
        checks++; if (wr_en !== 1'b1 || din !== 8'h55) begin errors++; $display("FAIL th_beat: got wr_en=%b din=%h, expected 1/55", wr_en, din); end
        tick;
        valid = '0; last = '0; fifo_num = '0; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL th_end: got %b, expected 0000", grant); end
    endtask

    task automatic test_len_limit;
        logic [7:0] exp_d;
        do_reset;
        valid = 4'b0100; set_data(2, 8'hC0); #1;
        tick;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ll_grant: got %b, expected 0100", grant); end
        for (int b = 0; b < 4; b++) begin
            exp_d = 8'hC0 + 8'(b);
            set_data(2, exp_d); last = '0; #1;
            checks++; if (wr_en !== 1'b1 || din !== exp_d) begin errors++; $display("FAIL ll_beat %0d: got wr_en=%b din=%h, expected 1/%h", b, wr_en, din, exp_d); end
            checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL ll_err_early %0d: got %b, expected 0", b, pkt_err); end
            tick;
        end
        set_data(2, 8'hC4); #1;
        checks++; if (grant !== 4'b0000 || wr_en !== 1'b0) begin errors++; $display("FAIL ll_cut: got grant=%b wr_en=%b, expected 0000/0", grant, wr_en); end
        checks++; if (pkt_err !== 1'b1) begin errors++; $display("FAIL ll_err_pulse: got %b, expected 1", pkt_err); end
        tick;
        checks++; if (grant !== 4'b0100 || pkt_err !== 1'b0) begin errors++; $display("FAIL ll_regrant: got grant=%b err=%b, expected 0100/0", grant, pkt_err); end
        for (int b = 4; b < 6; b++) begin
            exp_d = 8'hC0 + 8'(b);
            set_data(2, exp_d); last = (b == 5) ? 4'b0100 : 4'b0000; #1;
            checks++; if (wr_en !== 1'b1 || din !== exp_d) begin errors++; $display("FAIL ll_beat %0d: got wr_en=%b din=%h, expected 1/%h", b, wr_en, din, exp_d); end
            checks++; if (pkt_err !== 1'b0) begin errors++; $display("FAIL ll_err_late %0d: got %b, expected 0", b, pkt_err); end
            tick;
        end
        valid = '0; last = '0; #1;
        checks++; if (grant !== 4'b0000 || pkt_err !== 1'b0) begin errors++; $display("FAIL ll_end: got grant=%b err=%b, expected 0000/0", grant, pkt_err); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_d;
        do_reset;
        valid = 4'b0001; set_data(0, 8'hD0); #1;
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_grant: got %b, expected 0001", grant); end
        for (int b = 0; b < 2; b++) begin
            exp_d = 8'hD0 + 8'(b);
            set_data(0, exp_d); #1;
            checks++; if (wr_en !== 1'b1 || din !== exp_d) begin errors++; $display("FAIL rm_beat %0d: got wr_en=%b din=%h, expected 1/%h", b, wr_en, din, exp_d); end
            tick;
        end
        set_data(0, 8'hD2); rst_n = 1'b0; #1;
        checks++; if (ready !== 4'b0000 || wr_en !== 1'b0) begin errors++; $display("FAIL rm_gate: got ready=%b wr_en=%b, expected 0000/0", ready, wr_en); end
        tick;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rm_state: got grant=%b busy=%b, expected 0000/0", grant, busy); end
        rst_n = 1'b1; valid = 4'b0011; set_data(1, 8'hE0);
        tick;
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rm_first: got %b, expected 0001", grant); end
        last = 4'b0001; #1;
        checks++; if (wr_en !== 1'b1 || din !== 8'hD2) begin errors++; $display("FAIL rm_resume: got wr_en=%b din=%h, expected 1/d2", wr_en, din); end
        tick;
        valid = '0; last = '0; #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rm_end: got %b, expected 0000", grant); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_space_stall;
        test_start_thresh;
        test_len_limit;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
